// File: rtl/sensor_seq.sv
// sensor_seq -- frame sequencer for the high-speed sensor controller.
//
// Enables the controller, waits for its buffer to fill, copies every buffered
// word to system memory through a req/ack write port, clears the controller,
// and repeats for a programmed number of frames (or until stopped).
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start, stop      run control; stop is sticky until the run ends
//   base_addr        destination word address of the first frame (latched at start)
//   frame_cnt        frames per run, 0 = continuous (latched at start)
//   sctrl_en         controller sampling enable
//   sctrl_clear      one-cycle clear of the controller's counter and full flag
//   sctrl_addr       registered buffer read address
//   sctrl_interrupt  controller buffer full
//   sctrl_out        buffer read data, combinational from sctrl_addr
//   wr_req/wr_ack    memory write handshake; wr_addr/wr_data held until ack
//   busy             high in every state except IDLE
//   done             one-cycle pulse in the first IDLE cycle after a run
//   frames_done      frames completed in the current or last run
module sensor_seq #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int MAW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [MAW-1:0] base_addr,
  input  logic [7:0]     frame_cnt,
  output logic           sctrl_en,
  output logic           sctrl_clear,
  output logic [AW-1:0]  sctrl_addr,
  input  logic           sctrl_interrupt,
  input  logic [31:0]    sctrl_out,
  output logic           wr_req,
  output logic [MAW-1:0] wr_addr,
  output logic [31:0]    wr_data,
  input  logic           wr_ack,
  output logic           busy,
  output logic           done,
  output logic [7:0]     frames_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [MAW-1:0] dst_ptr_q, dst_ptr_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]     frames_done_q, frames_done_d;
  logic           stop_q, stop_d;
  logic [AW-1:0]  sctrl_addr_q, sctrl_addr_d;
  logic [MAW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           done_q, done_d;

  logic [7:0] frames_inc;
  logic       last_word;
  logic       stop_seen;

  assign frames_inc = (frames_done_q == 8'hFF) ? 8'hFF : frames_done_q + 8'd1;
  assign last_word  = (sctrl_addr_q == AW'(DEPTH - 1));
  // A stop sampled in the CLR cycle itself still ends the run at this boundary.
  assign stop_seen  = stop_q | stop;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    dst_ptr_d     = dst_ptr_q;
    frame_cnt_d   = frame_cnt_q;
    frames_done_d = frames_done_q;
    stop_d        = stop_q;
    sctrl_addr_d  = sctrl_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dst_ptr_d     = base_addr;
          frame_cnt_d   = frame_cnt;
          frames_done_d = 8'd0;
          // start+stop together yields exactly one frame.
          stop_d        = stop;
          state_d       = S_FILL;
        end
      end
      S_FILL: begin
        if (sctrl_interrupt) begin
          sctrl_addr_d = '0;
          state_d      = S_RD;
        end
      end
      S_RD: begin
        wr_data_d = sctrl_out;
        wr_addr_d = dst_ptr_q;
        state_d   = S_WR;
      end
      S_WR: begin
        if (wr_ack) begin
          // dst_ptr runs on across frames and wraps naturally at 2^MAW.
          dst_ptr_d    = dst_ptr_q + MAW'(1);
          sctrl_addr_d = sctrl_addr_q + AW'(1);
          state_d      = last_word ? S_CLR : S_RD;
        end
      end
      S_CLR: begin
        frames_done_d = frames_inc;
        if (stop_seen || (frame_cnt_q != 8'd0 && frames_inc == frame_cnt_q)) begin
          done_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, and the reset
  // branch gives every register a defined value so a reset mid-run drops
  // all control outputs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dst_ptr_q     <= '0;
      frame_cnt_q   <= '0;
      frames_done_q <= '0;
      stop_q        <= 1'b0;
      sctrl_addr_q  <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dst_ptr_q     <= dst_ptr_d;
      frame_cnt_q   <= frame_cnt_d;
      frames_done_q <= frames_done_d;
      stop_q        <= stop_d;
      sctrl_addr_q  <= sctrl_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      done_q        <= done_d;
    end
  end

  // Control strobes decode straight from the state register, so they are
  // glitch-free and sctrl_clear/sctrl_en can never overlap.
  assign sctrl_en    = (state_q == S_FILL);
  assign sctrl_clear = (state_q == S_CLR);
  assign wr_req      = (state_q == S_WR);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign sctrl_addr  = sctrl_addr_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frames_done = frames_done_q;

endmodule
